// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit that turns pipeline load/store
// controls into word-aligned data-memory bus transactions and extends load data.
// Ports:
//   clk, rst (async, active-low)
//   i_DM_read/i_DM_write/i_addr/i_wdata/i_wait_WFI : pipeline controls and operands
//   o_wait_DM1 : pipeline stall request
//   o_dm_out : extended load result
//   o_misalign : misaligned-access flag
//   dm_req/dm_we/dm_addr/dm_wstrb/dm_wdata : bus request
//   dm_gnt/dm_rvalid/dm_rdata : bus response
// Macro MEM_MISALIGN_TRAP_EN: flag misaligned accesses instead of issuing them
// (default: the offending low address bits are cleared).
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    i_DM_read,
  input  logic [1:0]    i_DM_write,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_wait_WFI,
  output logic          o_wait_DM1,
  output logic [31:0]   o_dm_out,
  output logic          o_misalign,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_wstrb,
  output logic [31:0]   dm_wdata,
  input  logic          dm_gnt,
  input  logic          dm_rvalid,
  input  logic [31:0]   dm_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic wr_acc, rd_acc, acc, trap, go, req;
  logic [1:0] sz, off;
  logic [31:0] rsh, ext;
  assign wr_acc = |i_DM_write;
  assign rd_acc = (i_DM_read != 3'd0) && (i_DM_read < 3'd6);
  assign acc = wr_acc | rd_acc;
  // access size: 0 byte, 1 halfword, 2 word; a store overrides a simultaneous load
  assign sz = wr_acc ? 2'(i_DM_write - 2'd1)
            : (i_DM_read == 3'd1 || i_DM_read == 3'd4) ? 2'd0
            : (i_DM_read == 3'd2 || i_DM_read == 3'd5) ? 2'd1 : 2'd2;
  // byte lane with sub-size address bits cleared to the natural alignment
  assign off = sz == 2'd0 ? i_addr[1:0] : sz == 2'd1 ? {i_addr[1], 1'b0} : 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = acc & ((sz == 2'd1 & i_addr[0]) | (sz == 2'd2 & |i_addr[1:0]));
`else
  assign trap = 1'b0;
`endif
  assign go = acc & ~trap;
  assign req = state_q == WAIT_GNT | (state_q == IDLE & go);
  assign rsh = dm_rdata >> {off, 3'b000};
  assign ext = i_DM_read == 3'd1 ? {{24{rsh[7]}}, rsh[7:0]}
             : i_DM_read == 3'd2 ? {{16{rsh[15]}}, rsh[15:0]}
             : i_DM_read == 3'd4 ? {24'd0, rsh[7:0]}
             : i_DM_read == 3'd5 ? {16'd0, rsh[15:0]} : rsh;
  always_comb begin
    state_d = (req & dm_gnt) ? (wr_acc ? DONE : WAIT_RSP)
            : (state_q == IDLE & go) ? WAIT_GNT
            : (state_q == WAIT_RSP & dm_rvalid) ? DONE
            : (state_q == DONE & ~i_wait_WFI) ? IDLE : state_q;
    hold_d = (state_q == WAIT_RSP & dm_rvalid) ? ext : hold_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
    end
  end
  // every output is gated by rst so the bus sees nothing while reset is held
  assign dm_req = rst & req;
  assign dm_we = dm_req & wr_acc;
  assign o_wait_DM1 = rst & (req | state_q == WAIT_RSP);
  assign o_misalign = rst & state_q == IDLE & trap;
  assign o_dm_out = (rst & state_q == DONE) ? hold_q : '0;
  assign dm_addr = dm_req ? {i_addr[AW-1:2], 2'b00} : '0;
  assign dm_wstrb = dm_we ? (sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? 4'b0011 << off : 4'b1111) : 4'b0000;
  assign dm_wdata = dm_we ? (sz == 2'd0 ? {4{i_wdata[7:0]}} : sz == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata) : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] i_DM_read = '0;
  logic [1:0] i_DM_write = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic i_wait_WFI = 1'b0;
  logic o_wait_DM1, o_misalign, dm_req, dm_we;
  logic [31:0] o_dm_out, dm_addr, dm_wdata;
  logic [3:0] dm_wstrb;
  logic dm_gnt = 1'b0;
  logic dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;
  int errors = 0;
  int checks = 0;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .i_DM_read(i_DM_read), .i_DM_write(i_DM_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wait_WFI(i_wait_WFI),
    .o_wait_DM1(o_wait_DM1), .o_dm_out(o_dm_out), .o_misalign(o_misalign),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, 32'(dm_req), 0);
    chk({tag, "_stall"}, 32'(o_wait_DM1), 0);
    chk({tag, "_out"}, o_dm_out, 0);
  endtask
  // gd: cycles before grant, rl: cycles from grant to rvalid (>=1), wfi: extra DONE cycles
  task automatic run_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat, input int gd, input int rl, input int wfi);
    int sz, lane, done_c;
    logic store, sgn;
    logic [31:0] m, ld, strb, wexp;
    store = wr != 0;
    sz = store ? (wr == 1 ? 1 : wr == 2 ? 2 : 4) : (rd == 1 || rd == 4) ? 1 : (rd == 2 || rd == 5) ? 2 : 4;
    lane = int'(addr[1:0]) & ~(sz - 1);
    m = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    ld = (rdat >> (8 * lane)) & m;
    sgn = rd == 1 || rd == 2;
    if (!store && sgn && ld[8 * sz - 1]) ld = ld | ~m;
    strb = 32'((1 << sz) - 1) << lane;
    for (int i = 0; i < 4; i++) wexp[8 * i +: 8] = wd[8 * (i % sz) +: 8];
    done_c = store ? gd + 1 : gd + rl + 1;
    i_DM_read = rd;
    i_DM_write = wr;
    i_addr = addr;
    i_wdata = wd;
    dm_rdata = rdat;
    dm_rvalid = 1'b0;
    i_wait_WFI = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((int'(addr[1:0]) & (sz - 1)) != 0) begin
      for (int c = 0; c < 2; c++) begin
        dm_gnt = 1'b1;
        @(negedge clk);
        chk("trap_flag", 32'(o_misalign), 1);
        chk_quiet("trap");
        @(posedge clk);
        #1;
      end
      dm_gnt = 1'b0;
      i_DM_read = '0;
      i_DM_write = '0;
      @(negedge clk);
      chk("trap_clear", 32'(o_misalign), 0);
      chk_quiet("trap_idle");
      @(posedge clk);
      #1;
      return;
    end
`endif
    dm_gnt = gd == 0;
    for (int c = 0; c <= done_c + wfi; c++) begin
      @(negedge clk);
      chk("req", 32'(dm_req), 32'(c <= gd));
      chk("stall", 32'(o_wait_DM1), 32'(c < done_c));
      if (c == 0) chk("misalign", 32'(o_misalign), 0);
      if (c == gd) begin
        chk("addr", dm_addr, addr & ~32'd3);
        chk("we", 32'(dm_we), 32'(store));
        chk("wstrb", 32'(dm_wstrb), store ? strb : 0);
        if (store) chk("wdata", dm_wdata, wexp);
      end
      if (c >= done_c && !store) chk("dm_out", o_dm_out, ld);
      @(posedge clk);
      #1;
      dm_gnt = c + 1 == gd;
      dm_rvalid = !store && (c + 1 == gd + rl);
      i_wait_WFI = (c + 1 >= done_c) && (c + 1 < done_c + wfi);
      if (c == done_c + wfi) begin
        i_DM_read = '0;
        i_DM_write = '0;
      end
    end
    @(negedge clk);
    chk_quiet("idle");
    @(posedge clk);
    #1;
  endtask
  initial begin
    i_DM_read = 3'd3;
    i_addr = 32'h100;
    #2;
    @(negedge clk);
    chk_quiet("rst0");
    chk("rst0_addr", dm_addr, 0);
    i_DM_read = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_txn(3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 0);
    run_txn(3'd0, 2'd1, 32'h103, 32'h000000A5, 32'h0, 3, 1, 0);
    run_txn(3'd2, 2'd0, 32'h102, 32'h0, 32'h80F17F00, 0, 1, 0);
    run_txn(3'd5, 2'd0, 32'h102, 32'h0, 32'h80F17F00, 0, 1, 0);
    run_txn(3'd1, 2'd0, 32'h101, 32'h0, 32'h80F17F00, 0, 1, 0);
    run_txn(3'd3, 2'd0, 32'h200, 32'h0, 32'h12345678, 1, 2, 2);
    run_txn(3'd3, 2'd0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1, 0);
    run_txn(3'd4, 2'd2, 32'h006, 32'h1234ABCD, 32'h0, 1, 1, 0);
    i_DM_read = 3'd6;
    i_addr = 32'h40;
    @(negedge clk);
    chk_quiet("rd6");
    i_DM_read = 3'd7;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_quiet("rd7");
    i_DM_read = 3'd3;
    i_addr = 32'h300;
    dm_gnt = 1'b1;
    @(posedge clk);
    #1;
    dm_gnt = 1'b0;
    @(negedge clk);
    chk("wrsp_stall", 32'(o_wait_DM1), 1);
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_we", 32'(dm_we), 0);
    chk("rst_mid_strb", 32'(dm_wstrb), 0);
    chk("rst_mid_mis", 32'(o_misalign), 0);
    @(posedge clk);
    #1;
    i_DM_read = '0;
    rst = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk_quiet("stale_rv");
    @(posedge clk);
    #1;
    dm_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_quiet("post_rst");
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [2:0] rd;
      logic [1:0] wr;
      op = $urandom_range(0, 7);
      rd = op < 5 ? 3'(op + 1) : 3'($urandom_range(0, 7));
      wr = op < 5 ? 2'd0 : 2'(op - 4);
      run_txn(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
